inst_trace_buf: RTL and testbench
=================================

INST_TRACE_BUF -- requirements
Module: inst_trace_buf

Interface
REQ-001 Parameter DEPTH, default 8, number of trace entries; power of two, 2..256.
REQ-002 Parameter CHARS, default 6, mnemonic field width in ASCII characters (8*CHARS bits).
REQ-003 Parameter OVERWRITE, default 0; 0 = drop new entry when full, 1 = overwrite oldest entry when full.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  retired-instruction strobe, one entry per high cycle.
REQ-007 in_pc  in  32  PC of the retired instruction.
REQ-008 in_instr  in  32  retired instruction word.
REQ-009 freeze  in  1  while high, captures are ignored and not counted as drops.
REQ-010 clr  in  1  synchronous flush of buffer and counters.
REQ-011 out_valid  out  1  head entry available.
REQ-012 out_ready  in  1  consumer accepts head entry.
REQ-013 out_pc  out  32  head entry PC.
REQ-014 out_instr  out  32  head entry instruction word.
REQ-015 out_ascii  out  8*CHARS  head entry mnemonic, left-justified, space-padded.
REQ-016 count  out  $clog2(DEPTH)+1  entries held.
REQ-017 drop_cnt  out  16  entries lost (dropped or overwritten), saturating at 0xFFFF.

Function
REQ-018 Decode SHALL be MIPS32 standard encoding for the team's 57-instruction set (R-type by funct, REGIMM by rt, COP0 MFC0/MTC0/ERET, I/J-type by opcode); word 0x00000000 -> "NOP", 0x42000018 -> "ERET", any other unlisted encoding -> "N-R".
REQ-019 Mnemonics longer than CHARS SHALL be truncated on the right; shorter padded with 0x20.
REQ-020 Decode SHALL be registered: an entry captured at edge N is visible on out_* after edge N+1 (2-cycle in-to-out latency on empty buffer).
REQ-021 Buffer is a circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-022 Handshake: head pops on the edge where out_valid and out_ready are both high; out_* stable while out_valid high and out_ready low.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged, including when full; no drop occurs.
REQ-024 Push when full without pop: OVERWRITE=0 discards the new entry; OVERWRITE=1 discards the head and advances both pointers; either case increments drop_cnt.
REQ-025 Pop when empty SHALL have no effect; out_valid low when count is 0.
REQ-026 clr SHALL have priority over push and pop in the same cycle; count, drop_cnt, pointers become 0 on the next edge.
REQ-027 Entries in the decode stage when clr or freeze rises SHALL be discarded on clr and completed on freeze.

Reset
REQ-028 On rst_n low: pointers, count, drop_cnt = 0; out_valid = 0; out_pc, out_instr = 0; out_ascii = all spaces; decode stage empty.
REQ-029 Reset mid-transfer SHALL abandon all entries; no entry SHALL appear after rst_n rises until a new in_valid.

Configuration
REQ-030 Macro TRACE_ASCII_EN: defined, out_ascii carries the decoded mnemonic per REQ-018; undefined, decode logic and ascii storage are removed, out_ascii is tied to all spaces, and latency per REQ-020 remains unchanged.

Verification
REQ-031 Reset, push in_instr=0x00000000 pc=0xBFC00000 -> after 2 cycles out_valid=1, out_ascii="NOP   ", count=1.
REQ-032 DEPTH=8, OVERWRITE=0, 10 pushes, out_ready=0 -> count=8, drop_cnt=2, head pc is first pushed.
REQ-033 Same with OVERWRITE=1 -> count=8, drop_cnt=2, head pc is third pushed.
REQ-034 Full buffer, in_valid and out_ready high 20 cycles -> count stays 8, drop_cnt unchanged, output order matches input order across pointer wrap.
REQ-035 Push 0x42000018, 0x24020001, 0xFC000000 -> "ERET  ", "ADDIU ", "N-R   " in order.
REQ-036 clr and in_valid same cycle with count=5 -> count=0, drop_cnt=0, out_valid=0 next cycle; rst_n pulse mid-stream -> count=0 asynchronously.

Source files
------------

// File: rtl/inst_trace_buf_if.sv
// Trace buffer bus: capture side, consumer handshake and status counters.
// The master modport is the system/bench side, the slave modport is the buffer.
interface inst_trace_buf_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CHARS = 6
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic [31:0]          in_pc;
    logic [31:0]          in_instr;
    logic                 freeze;
    logic                 clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [31:0]          out_instr;
    logic [8*CHARS-1:0]   out_ascii;
    logic [CW-1:0]        count;
    logic [15:0]          drop_cnt;

    modport master (
        output in_valid, in_pc, in_instr, freeze, clr, out_ready,
        input  out_valid, out_pc, out_instr, out_ascii, count, drop_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_instr, freeze, clr, out_ready,
        output out_valid, out_pc, out_instr, out_ascii, count, drop_cnt
    );
endinterface

// File: rtl/inst_trace_buf.sv
// Retired-instruction trace FIFO with a registered MIPS32 mnemonic decode stage.
// Define TRACE_ASCII_EN to build the decoder and ascii storage; otherwise out_ascii is all spaces.
module inst_trace_buf #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CHARS     = 6,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_trace_buf_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned AB = 8 * CHARS;

    logic          r_d_valid;
    logic [31:0]   r_d_pc;
    logic [31:0]   r_d_instr;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_drop;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_ovr;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = r_d_valid;
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_ovr   = w_push && w_full && !w_pop;
    // When full with a simultaneous pop, wptr equals rptr, so writing the head slot is safe.
    assign w_wr    = !bus.clr && w_push && (!w_full || w_pop || (OVERWRITE != 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid <= 1'b0;
            r_d_pc    <= '0;
            r_d_instr <= '0;
        end else begin
            r_d_valid <= bus.in_valid && !bus.freeze && !bus.clr;
            if (bus.in_valid && !bus.freeze) begin
                r_d_pc    <= bus.in_pc;
                r_d_instr <= bus.in_instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else if (bus.clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop || (w_ovr && (OVERWRITE != 0))) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop && !w_full) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_ovr && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_pc[r_wptr]    <= r_d_pc;
            r_mem_instr[r_wptr] <= r_d_instr;
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_pc    = w_empty ? '0 : r_mem_pc[r_rptr];
    assign bus.out_instr = w_empty ? '0 : r_mem_instr[r_rptr];
    assign bus.count     = r_count;
    assign bus.drop_cnt  = r_drop;

`ifdef TRACE_ASCII_EN
    logic [AB-1:0] r_mem_ascii [DEPTH];
    logic [63:0]   w_mnem;
    logic [AB-1:0] w_d_ascii;

    function automatic logic [63:0] f_mnem(input logic [31:0] instr);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [63:0] m;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        fn = instr[5:0];
        m  = "N-R     ";
        if (instr == 32'h0000_0000) begin
            m = "NOP     ";
        end else begin
            case (op)
                6'h00: case (fn)
                    6'h00: m = "SLL     ";  6'h02: m = "SRL     ";  6'h03: m = "SRA     ";
                    6'h04: m = "SLLV    ";  6'h06: m = "SRLV    ";  6'h07: m = "SRAV    ";
                    6'h08: m = "JR      ";  6'h09: m = "JALR    ";  6'h0C: m = "SYSCALL ";
                    6'h0D: m = "BREAK   ";  6'h10: m = "MFHI    ";  6'h11: m = "MTHI    ";
                    6'h12: m = "MFLO    ";  6'h13: m = "MTLO    ";  6'h18: m = "MULT    ";
                    6'h19: m = "MULTU   ";  6'h1A: m = "DIV     ";  6'h1B: m = "DIVU    ";
                    6'h20: m = "ADD     ";  6'h21: m = "ADDU    ";  6'h22: m = "SUB     ";
                    6'h23: m = "SUBU    ";  6'h24: m = "AND     ";  6'h25: m = "OR      ";
                    6'h26: m = "XOR     ";  6'h27: m = "NOR     ";  6'h2A: m = "SLT     ";
                    6'h2B: m = "SLTU    ";
                    default: m = "N-R     ";
                endcase
                6'h01: case (rt)
                    5'h00: m = "BLTZ    ";  5'h01: m = "BGEZ    ";
                    5'h10: m = "BLTZAL  ";  5'h11: m = "BGEZAL  ";
                    default: m = "N-R     ";
                endcase
                6'h10: begin
                    if (instr == 32'h4200_0018) m = "ERET    ";
                    else if (rs == 5'h00)       m = "MFC0    ";
                    else if (rs == 5'h04)       m = "MTC0    ";
                end
                6'h02: m = "J       ";  6'h03: m = "JAL     ";  6'h04: m = "BEQ     ";
                6'h05: m = "BNE     ";  6'h06: m = "BLEZ    ";  6'h07: m = "BGTZ    ";
                6'h08: m = "ADDI    ";  6'h09: m = "ADDIU   ";  6'h0A: m = "SLTI    ";
                6'h0B: m = "SLTIU   ";  6'h0C: m = "ANDI    ";  6'h0D: m = "ORI     ";
                6'h0E: m = "XORI    ";  6'h0F: m = "LUI     ";  6'h20: m = "LB      ";
                6'h21: m = "LH      ";  6'h23: m = "LW      ";  6'h24: m = "LBU     ";
                6'h25: m = "LHU     ";  6'h28: m = "SB      ";  6'h29: m = "SH      ";
                6'h2B: m = "SW      ";
                default: m = "N-R     ";
            endcase
        end
        return m;
    endfunction

    assign w_mnem = f_mnem(r_d_instr);

    // Mnemonics are stored 8 chars wide, space-padded; fit them to CHARS here.
    always_comb begin
        w_d_ascii = {CHARS{8'h20}};
        for (int unsigned i = 0; i < CHARS; i++) begin
            if (i < 8) begin
                w_d_ascii[AB-1-8*i -: 8] = w_mnem[63-8*((i < 8) ? i : 0) -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_ascii[r_wptr] <= w_d_ascii;
        end
    end

    assign bus.out_ascii = w_empty ? {CHARS{8'h20}} : r_mem_ascii[r_rptr];
`else
    assign bus.out_ascii = {CHARS{8'h20}};
`endif
endmodule

// File: tb/tb_inst_trace_buf.sv
// Bench for inst_trace_buf: drop (OVERWRITE=0) and overwrite (OVERWRITE=1) instances on shared stimulus,
// checked against a queue-based reference model; mnemonic expectations follow TRACE_ASCII_EN.
module tb_inst_trace_buf;
    localparam int DEPTH = 8;
    localparam int CHARS = 6;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 1 + CW + 16 + 64 + 8 * CHARS;
    localparam logic [8*CHARS-1:0] SP = {CHARS{8'h20}};
`ifdef TRACE_ASCII_EN
    localparam logic [8*CHARS-1:0] S_NOP   = "NOP   ";
    localparam logic [8*CHARS-1:0] S_ERET  = "ERET  ";
    localparam logic [8*CHARS-1:0] S_ADDIU = "ADDIU ";
    localparam logic [8*CHARS-1:0] S_NR    = "N-R   ";
`else
    localparam logic [8*CHARS-1:0] S_NOP   = SP;
    localparam logic [8*CHARS-1:0] S_ERET  = SP;
    localparam logic [8*CHARS-1:0] S_ADDIU = SP;
    localparam logic [8*CHARS-1:0] S_NR    = SP;
`endif

    logic clk, rst_n;
    logic in_valid, freeze, clr, out_ready;
    logic [31:0] in_pc, in_instr;
    int n_tests, n_fail;

    inst_trace_buf_if #(.DEPTH(DEPTH), .CHARS(CHARS)) bus0 ();
    inst_trace_buf_if #(.DEPTH(DEPTH), .CHARS(CHARS)) bus1 ();

    assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
    assign bus0.in_pc = in_pc;         assign bus1.in_pc = in_pc;
    assign bus0.in_instr = in_instr;   assign bus1.in_instr = in_instr;
    assign bus0.freeze = freeze;       assign bus1.freeze = freeze;
    assign bus0.clr = clr;             assign bus1.clr = clr;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

    inst_trace_buf #(.DEPTH(DEPTH), .CHARS(CHARS), .OVERWRITE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    inst_trace_buf #(.DEPTH(DEPTH), .CHARS(CHARS), .OVERWRITE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [VW-1:0] got0, got1;
    assign got0 = {bus0.out_valid, bus0.count, bus0.drop_cnt, bus0.out_pc, bus0.out_instr, bus0.out_ascii};
    assign got1 = {bus1.out_valid, bus1.count, bus1.drop_cnt, bus1.out_pc, bus1.out_instr, bus1.out_ascii};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue of {pc,instr} per instance plus the single in-flight entry.
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int drops0, drops1;
    logic pend_v;
    logic [63:0] pend;

`ifdef TRACE_ASCII_EN
    function automatic string mnem(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic [5:0] fn = w[5:0];
        logic [4:0] rs = w[25:21];
        logic [4:0] rt = w[20:16];
        if (w == 32'h0) return "NOP";
        if (w == 32'h42000018) return "ERET";
        case (op)
            0: case (fn)
                0: return "SLL"; 2: return "SRL"; 3: return "SRA"; 4: return "SLLV"; 6: return "SRLV";
                7: return "SRAV"; 8: return "JR"; 9: return "JALR"; 12: return "SYSCALL"; 13: return "BREAK";
                16: return "MFHI"; 17: return "MTHI"; 18: return "MFLO"; 19: return "MTLO"; 24: return "MULT";
                25: return "MULTU"; 26: return "DIV"; 27: return "DIVU"; 32: return "ADD"; 33: return "ADDU";
                34: return "SUB"; 35: return "SUBU"; 36: return "AND"; 37: return "OR"; 38: return "XOR";
                39: return "NOR"; 42: return "SLT"; 43: return "SLTU";
                default: return "N-R";
            endcase
            1: case (rt)
                0: return "BLTZ"; 1: return "BGEZ"; 16: return "BLTZAL"; 17: return "BGEZAL";
                default: return "N-R";
            endcase
            16: begin
                if (rs == 0) return "MFC0";
                if (rs == 4) return "MTC0";
                return "N-R";
            end
            2: return "J"; 3: return "JAL"; 4: return "BEQ"; 5: return "BNE"; 6: return "BLEZ"; 7: return "BGTZ";
            8: return "ADDI"; 9: return "ADDIU"; 10: return "SLTI"; 11: return "SLTIU"; 12: return "ANDI";
            13: return "ORI"; 14: return "XORI"; 15: return "LUI"; 32: return "LB"; 33: return "LH";
            35: return "LW"; 36: return "LBU"; 37: return "LHU"; 40: return "SB"; 41: return "SH"; 43: return "SW";
            default: return "N-R";
        endcase
    endfunction
`endif

    function automatic logic [8*CHARS-1:0] exp_ascii(input logic [31:0] w);
        logic [8*CHARS-1:0] r;
        r = SP;
`ifdef TRACE_ASCII_EN
        begin
            string s;
            s = mnem(w);
            for (int i = 0; i < CHARS; i++)
                if (i < s.len()) r[8*(CHARS-1-i) +: 8] = s[i];
        end
`endif
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int k);
        logic [63:0] h;
        int n, d;
        if (k == 0) begin n = q0.size(); h = (n > 0) ? q0[0] : 64'h0; d = drops0; end
        else        begin n = q1.size(); h = (n > 0) ? q1[0] : 64'h0; d = drops1; end
        return {n > 0, CW'(n), d[15:0], h, (n > 0) ? exp_ascii(h[31:0]) : SP};
    endfunction

    task automatic upd(input bit ow, inout logic [63:0] q[$], inout int drops);
        bit pop;
        pop = (q.size() > 0) && out_ready;
        if (clr) begin
            q.delete();
            drops = 0;
        end else if (pend_v) begin
            if (pop) begin
                void'(q.pop_front());
                q.push_back(pend);
            end else if (q.size() < DEPTH) begin
                q.push_back(pend);
            end else begin
                if (drops < 65535) drops++;
                if (ow) begin
                    void'(q.pop_front());
                    q.push_back(pend);
                end
            end
        end else if (pop) begin
            void'(q.pop_front());
        end
    endtask

    task automatic model_edge();
        upd(1'b0, q0, drops0);
        upd(1'b1, q1, drops1);
        pend_v = in_valid && !freeze && !clr;
        pend = {in_pc, in_instr};
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        drops0 = 0; drops1 = 0;
        pend_v = 1'b0; pend = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        in_valid = 0; freeze = 0; clr = 0; out_ready = 0; in_pc = '0; in_instr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if (got0 !== {1'b0, CW'(0), 16'h0, 64'h0, SP}) begin
            n_fail++; $display("FAIL reset_dut0 got=%h exp=%h", got0, {1'b0, CW'(0), 16'h0, 64'h0, SP});
        end
        n_tests++;
        if (got1 !== {1'b0, CW'(0), 16'h0, 64'h0, SP}) begin
            n_fail++; $display("FAIL reset_dut1 got=%h exp=%h", got1, {1'b0, CW'(0), 16'h0, 64'h0, SP});
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_nop_latency();
        in_valid = 1; in_pc = 32'hBFC00000; in_instr = 32'h0;
        cycle();
        in_valid = 0;
        n_tests++;
        if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL nop_early got=%b exp=0", bus0.out_valid); end
        cycle();
        n_tests++;
        if ({bus0.out_valid, bus0.count, bus0.out_pc, bus0.out_ascii} !== {1'b1, CW'(1), 32'hBFC00000, S_NOP}) begin
            n_fail++;
            $display("FAIL nop_out got=%b/%0d/%h/%h exp=1/1/bfc00000/%h",
                     bus0.out_valid, bus0.count, bus0.out_pc, bus0.out_ascii, S_NOP);
        end
        out_ready = 1; cycle(); out_ready = 0;
        n_tests++;
        if (bus0.count !== CW'(0)) begin n_fail++; $display("FAIL nop_pop got=%0d exp=0", bus0.count); end
    endtask

    task automatic test_fill_drop();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_pc = 32'h1000 + 4 * i; in_instr = 32'h24000000 | i;
            cycle();
        end
        in_valid = 0;
        cycle();
        n_tests++;
        if ({bus0.count, bus0.drop_cnt, bus0.out_pc} !== {CW'(8), 16'd2, 32'h1000}) begin
            n_fail++; $display("FAIL fill_drop got=%0d/%0d/%h exp=8/2/1000", bus0.count, bus0.drop_cnt, bus0.out_pc);
        end
        n_tests++;
        if ({bus1.count, bus1.drop_cnt, bus1.out_pc} !== {CW'(8), 16'd2, 32'h1008}) begin
            n_fail++; $display("FAIL fill_ovr got=%0d/%0d/%h exp=8/2/1008", bus1.count, bus1.drop_cnt, bus1.out_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0, e1;
        in_valid = 1; in_pc = 32'h2000; in_instr = 32'h00851020;
        cycle();
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            e0 = (i < 8) ? 32'h1000 + 4 * i : 32'h2000 + 4 * (i - 8);
            e1 = (i < 8) ? 32'h1008 + 4 * i : 32'h2000 + 4 * (i - 8);
            n_tests++;
            if ({bus0.out_pc, bus1.out_pc} !== {e0, e1}) begin
                n_fail++; $display("FAIL b2b_order i=%0d got=%h/%h exp=%h/%h", i, bus0.out_pc, bus1.out_pc, e0, e1);
            end
            in_pc = 32'h2000 + 4 * (i + 1);
            cycle();
            n_tests++;
            if ({bus0.count, bus0.drop_cnt, bus1.count, bus1.drop_cnt} !== {CW'(8), 16'd2, CW'(8), 16'd2}) begin
                n_fail++;
                $display("FAIL b2b_level i=%0d got=%0d/%0d/%0d/%0d exp=8/2/8/2",
                         i, bus0.count, bus0.drop_cnt, bus1.count, bus1.drop_cnt);
            end
        end
        in_valid = 0;
        cycle();
        out_ready = 0;
        n_tests++;
        if (got0 !== exp_vec(0)) begin n_fail++; $display("FAIL b2b_end got=%h exp=%h", got0, exp_vec(0)); end
    endtask

    task automatic test_decode();
        logic [31:0] words [3];
        logic [8*CHARS-1:0] names [3];
        words[0] = 32'h42000018; words[1] = 32'h24020001; words[2] = 32'hFC000000;
        names[0] = S_ERET;       names[1] = S_ADDIU;      names[2] = S_NR;
        clr = 1; cycle(); clr = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_pc = 32'h3000 + 4 * i; in_instr = words[i];
            cycle();
        end
        in_valid = 0;
        cycle();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({bus0.out_instr, bus0.out_ascii} !== {words[i], names[i]}) begin
                n_fail++;
                $display("FAIL decode i=%0d got=%h/%h exp=%h/%h", i, bus0.out_instr, bus0.out_ascii, words[i], names[i]);
            end
            cycle();
        end
        out_ready = 0;
    endtask

    task automatic test_clr();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_pc = 32'h4000 + 4 * i; in_instr = 32'h8c820000;
            cycle();
        end
        in_valid = 0;
        cycle();
        out_ready = 1;
        repeat (3) cycle();
        out_ready = 0;
        n_tests++;
        if ({bus0.count, bus0.drop_cnt, bus1.count} !== {CW'(5), 16'd4, CW'(5)}) begin
            n_fail++; $display("FAIL clr_pre got=%0d/%0d/%0d exp=5/4/5", bus0.count, bus0.drop_cnt, bus1.count);
        end
        clr = 1; in_valid = 1; in_pc = 32'h4FFC;
        cycle();
        clr = 0; in_valid = 0;
        n_tests++;
        if ({bus0.count, bus0.drop_cnt, bus0.out_valid, bus1.count, bus1.drop_cnt, bus1.out_valid} !==
            {CW'(0), 16'd0, 1'b0, CW'(0), 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL clr got=%0d/%0d/%b/%0d/%0d/%b exp=0/0/0/0/0/0",
                     bus0.count, bus0.drop_cnt, bus0.out_valid, bus1.count, bus1.drop_cnt, bus1.out_valid);
        end
        cycle();
        n_tests++;
        if (got0 !== exp_vec(0)) begin n_fail++; $display("FAIL clr_after got=%h exp=%h", got0, exp_vec(0)); end
    endtask

    task automatic test_freeze();
        in_valid = 1; in_pc = 32'h5000; in_instr = 32'h3c010000;
        cycle();
        freeze = 1; in_pc = 32'h5004;
        repeat (4) cycle();
        freeze = 0; in_valid = 0;
        cycle();
        n_tests++;
        if ({bus0.count, bus0.drop_cnt, bus0.out_pc} !== {CW'(1), 16'd0, 32'h5000}) begin
            n_fail++; $display("FAIL freeze got=%0d/%0d/%h exp=1/0/5000", bus0.count, bus0.drop_cnt, bus0.out_pc);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h6000 + 4 * i; in_instr = 32'hac820000;
            cycle();
        end
        #2 rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if ({bus0.count, bus0.out_valid, bus1.count, bus1.out_valid} !== {CW'(0), 1'b0, CW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async got=%0d/%b/%0d/%b exp=0/0/0/0", bus0.count, bus0.out_valid, bus1.count, bus1.out_valid);
        end
        @(posedge clk);
        #2 rst_n = 1; in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++;
            if ({bus0.count, bus1.count} !== {CW'(0), CW'(0)}) begin
                n_fail++; $display("FAIL reset_ghost i=%0d got=%0d/%0d exp=0/0", i, bus0.count, bus1.count);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [14];
        pool[0] = 32'h00000000; pool[1] = 32'h42000018; pool[2] = 32'h24020001; pool[3] = 32'hFC000000;
        pool[4] = 32'h0000000C; pool[5] = 32'h04110000; pool[6] = 32'h40806000; pool[7] = 32'h40026000;
        pool[8] = 32'h00851020; pool[9] = 32'h8C820000; pool[10] = 32'hAC820000; pool[11] = 32'h08000000;
        pool[12] = 32'h3C010000; pool[13] = 32'h00000008;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            freeze    = ($urandom % 16) == 0;
            clr       = ($urandom % 40) == 0;
            in_pc     = $urandom;
            in_instr  = ($urandom % 2) ? $urandom : pool[$urandom % 14];
            cycle();
            n_tests++;
            if (got0 !== exp_vec(0)) begin n_fail++; $display("FAIL rand_dut0 i=%0d got=%h exp=%h", i, got0, exp_vec(0)); end
            n_tests++;
            if (got1 !== exp_vec(1)) begin n_fail++; $display("FAIL rand_dut1 i=%0d got=%h exp=%h", i, got1, exp_vec(1)); end
        end
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        cycle();
        test_nop_latency();
        test_fill_drop();
        test_back_to_back();
        test_decode();
        test_clr();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
